// File: rtl/apb_pkg.sv
// Shared types and defaults for the APB requester and its wait timer.
package apb_pkg;

  localparam int unsigned APB_ADDR_W  = 32;
  localparam int unsigned APB_DATA_W  = 8;
  localparam int unsigned APB_TIMEOUT = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  typedef struct packed {
    logic [APB_DATA_W-1:0] rdata;
    logic                  err;
    logic                  timeout;
  } apb_rsp_t;

endpackage

// File: rtl/apb_wait_timer.sv
// Counts ACCESS wait states; limit_o flags the last cycle allowed before abort.
module apb_wait_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic pclk,
  input  logic prset,
  input  logic clear_i,
  input  logic enable_i,
  output logic limit_o
);

  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge pclk or negedge prset) begin
    if (!prset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign limit_o = (cnt_q == LIMIT);

endmodule

// File: rtl/apb_master.sv
// APB requester: one command at a time through SETUP/ACCESS with a bounded pready wait.
module apb_master
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W  = APB_ADDR_W,
  parameter int unsigned DATA_W  = APB_DATA_W,
  parameter int unsigned TIMEOUT = APB_TIMEOUT
) (
  input  logic              pclk,
  input  logic              prset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic              pready,
  input  logic [DATA_W-1:0] pread,
  input  logic              perr
);

  apb_state_e        state_q, state_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_timeout_q, rsp_timeout_d;
  logic              tmr_clear, tmr_enable, tmr_limit;

  apb_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .pclk     (pclk),
    .prset    (prset),
    .clear_i  (tmr_clear),
    .enable_i (tmr_enable),
    .limit_o  (tmr_limit)
  );

  always_comb begin
    state_d       = state_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    tmr_clear     = 1'b0;
    tmr_enable    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          paddr_d   = cmd_addr;
          pwrite_d  = cmd_write;
          pwdata_d  = cmd_write ? cmd_wdata : '0;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          tmr_clear = 1'b1;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        // pready is checked before the limit so a late completion still counts as success.
        if (pready) begin
          rsp_rdata_d   = (pwrite_q || perr) ? '0 : pread;
          rsp_err_d     = perr;
          rsp_timeout_d = 1'b0;
          rsp_valid_d   = 1'b1;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          state_d       = RESP;
        end else if (tmr_limit) begin
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_valid_d   = 1'b1;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          state_d       = RESP;
        end else begin
          tmr_enable = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge prset) begin
    if (!prset) begin
      state_q       <= IDLE;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign cmd_ready   = (state_q == IDLE);
  assign psel        = psel_q;
  assign penable     = penable_q;
  assign pwrite      = pwrite_q;
  assign paddr       = paddr_q;
  assign pwdata      = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master against a small behavioural 32-byte APB completer.
module tb_apb_master;

  logic        pclk;
  logic        prset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [7:0]  pwdata;
  logic        pready;
  logic [7:0]  pread;
  logic        perr;

  int n_checks = 0;
  int n_fail   = 0;

  apb_master #(
    .ADDR_W  (32),
    .DATA_W  (8),
    .TIMEOUT (16)
  ) dut (
    .pclk        (pclk),
    .prset       (prset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .psel        (psel),
    .penable     (penable),
    .pwrite      (pwrite),
    .paddr       (paddr),
    .pwdata      (pwdata),
    .pready      (pready),
    .pread       (pread),
    .perr        (perr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Behavioural completer: wait_n wait states, hang never answers, addr >= 32 errors.
  logic [7:0] mem [0:31];
  int         wait_n = 0;
  bit         hang   = 1'b0;
  int         wcnt   = 0;
  logic       in_access;

  assign in_access = psel & penable;
  assign pready    = in_access & !hang & (wcnt == wait_n);
  assign perr      = pready & (paddr >= 32'd32);
  assign pread     = (paddr < 32'd32) ? mem[paddr[4:0]] : 8'h00;

  always @(posedge pclk) begin
    if (in_access && !pready) wcnt <= wcnt + 1;
    else                      wcnt <= 0;
    if (pready && pwrite && !perr) mem[paddr[4:0]] <= pwdata;
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [7:0] wd);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wd;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (!rsp_valid && n < 40) begin
      tick();
      n++;
    end
    chk_eq("drain_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    int pen_cnt;
    prset     = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b0;
    tick();
    tick();
    chk_eq("rst_psel", {31'd0, psel}, 32'd0);
    chk_eq("rst_penable", {31'd0, penable}, 32'd0);
    chk_eq("rst_paddr", paddr, 32'd0);
    chk_eq("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    prset = 1'b1;
    tick();
    chk_eq("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // 1: zero-wait write
    wait_n = 0;
    issue(1'b1, 32'h05, 8'hA5);
    chk_eq("t1_c1_psel", {31'd0, psel}, 32'd1);
    chk_eq("t1_c1_penable", {31'd0, penable}, 32'd0);
    chk_eq("t1_c1_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk_eq("t1_c1_pwdata", {24'd0, pwdata}, 32'hA5);
    tick();
    chk_eq("t1_c2_penable", {31'd0, penable}, 32'd1);
    tick();
    chk_eq("t1_c3_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk_eq("t1_c3_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk_eq("t1_c3_rsp_rdata", {24'd0, rsp_rdata}, 32'h00);
    chk_eq("t1_c3_psel", {31'd0, psel}, 32'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk_eq("t1_idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // 2: read back with 3 wait states, response in cycle 6
    wait_n = 3;
    issue(1'b0, 32'h05, 8'hFF);
    chk_eq("t2_c1_pwdata", {24'd0, pwdata}, 32'h00);
    for (int c = 1; c <= 5; c++) begin
      chk_eq("t2_paddr_stable", paddr, 32'h05);
      chk_eq("t2_no_rsp_yet", {31'd0, rsp_valid}, 32'd0);
      tick();
    end
    chk_eq("t2_c6_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk_eq("t2_c6_rsp_rdata", {24'd0, rsp_rdata}, 32'hA5);
    chk_eq("t2_c6_rsp_err", {31'd0, rsp_err}, 32'd0);
    drain();

    // 3: out-of-range read, completer flags perr
    wait_n = 0;
    issue(1'b0, 32'h20, 8'h00);
    tick();
    tick();
    chk_eq("t3_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk_eq("t3_rsp_err", {31'd0, rsp_err}, 32'd1);
    chk_eq("t3_rsp_timeout", {31'd0, rsp_timeout}, 32'd0);
    chk_eq("t3_rsp_rdata", {24'd0, rsp_rdata}, 32'h00);
    drain();

    // 4: completer never answers -> abort after 16 ACCESS cycles
    hang = 1'b1;
    issue(1'b0, 32'h07, 8'h00);
    tick();
    pen_cnt = 0;
    for (int c = 2; c <= 17; c++) begin
      if (penable) pen_cnt++;
      tick();
    end
    chk_eq("t4_access_cycles", pen_cnt, 32'd16);
    chk_eq("t4_psel_dropped", {31'd0, psel}, 32'd0);
    chk_eq("t4_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk_eq("t4_rsp_err", {31'd0, rsp_err}, 32'd1);
    chk_eq("t4_rsp_timeout", {31'd0, rsp_timeout}, 32'd1);
    chk_eq("t4_rsp_rdata", {24'd0, rsp_rdata}, 32'h00);
    drain();
    hang = 1'b0;

    // 5: response back-pressure while another command waits
    wait_n = 0;
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 32'h06;
    cmd_wdata = 8'h3C;
    tick();
    tick();
    tick();
    for (int c = 0; c < 4; c++) begin
      chk_eq("t5_rsp_held", {31'd0, rsp_valid}, 32'd1);
      chk_eq("t5_cmd_ready_low", {31'd0, cmd_ready}, 32'd0);
      chk_eq("t5_no_psel", {31'd0, psel}, 32'd0);
      tick();
    end
    cmd_write = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk_eq("t5_released_rsp", {31'd0, rsp_valid}, 32'd0);
    chk_eq("t5_released_ready", {31'd0, cmd_ready}, 32'd1);
    tick();
    cmd_valid = 1'b0;
    chk_eq("t5_next_psel", {31'd0, psel}, 32'd1);
    chk_eq("t5_next_paddr", paddr, 32'h06);
    tick();
    tick();
    chk_eq("t5_readback", {24'd0, rsp_rdata}, 32'h3C);
    drain();

    // 6: reset asserted during ACCESS
    hang = 1'b1;
    issue(1'b0, 32'h05, 8'h00);
    tick();
    chk_eq("t6_in_access", {31'd0, penable}, 32'd1);
    #2 prset = 1'b0;
    #1;
    chk_eq("t6_psel_async", {31'd0, psel}, 32'd0);
    chk_eq("t6_penable_async", {31'd0, penable}, 32'd0);
    tick();
    prset = 1'b1;
    hang  = 1'b0;
    tick();
    chk_eq("t6_no_rsp", {31'd0, rsp_valid}, 32'd0);
    chk_eq("t6_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk_eq("t6_psel_idle", {31'd0, psel}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
